// File: rtl/uart_pkg.sv
// Shared definitions for the OBI UART: register offsets, bit positions,
// the common TX/RX state encoding and the divisor clamp.
package uart_pkg;

    // Register offsets as seen on addr_i[3:2]
    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_BAUD   = 2'd2;
    localparam logic [1:0] REG_DATA   = 2'd3;

    // CTRL bit indices
    localparam int CTRL_TX_EN     = 0;
    localparam int CTRL_RX_EN     = 1;
    localparam int CTRL_RX_IRQ_EN = 2;

    // STATUS bit indices
    localparam int ST_TX_BUSY    = 0;
    localparam int ST_TX_FULL    = 1;
    localparam int ST_RX_VALID   = 2;
    localparam int ST_RX_OVERRUN = 3;
    localparam int ST_FRAME_ERR  = 4;

    // Smallest usable divisor: RX needs divisor/2 >= 1 for the start re-sample
    localparam logic [15:0] UART_DIV_MIN = 16'd2;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_e;

    // Effective clocks-per-bit derived from the BAUD register
    function automatic logic [15:0] eff_div(input logic [15:0] baud);
        return (baud < UART_DIV_MIN) ? UART_DIV_MIN : baud;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with show-ahead output. Pushes into a full FIFO
// and pops from an empty FIFO are ignored.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_push, do_pop;

    // Extra pointer MSB tells full apart from empty when the indices match
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem[rd_ptr_q[AW-1:0]];

    // Pointer advance
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end

    // Pointer registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage write; contents need no reset because the pointers gate reads
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q[AW-1:0]] <= din;
    end

endmodule

// File: rtl/obi_uart.sv
// OBI slave UART, 8N1. Zero-wait-state grant, one-cycle rvalid response,
// 4-deep TX FIFO, single RX holding register and level RX interrupt.
module obi_uart
    import uart_pkg::*;
#(
    parameter logic [15:0] DIV_RESET     = 16'd434,
    parameter int          TX_FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_i,
    output logic        gnt_o,
    output logic        rvalid_o,
    input  logic [31:0] addr_i,
    input  logic        we_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic        tx_o,
    input  logic        rx_i,
    output logic        irq_o
);
    // Bus / register state
    logic [2:0]  ctrl_q, ctrl_d;
    logic [15:0] baud_q, baud_d;
    logic        rvalid_q, rvalid_d;
    logic [31:0] rdata_q, rdata_d;
    logic        irq_q, irq_d;
    // TX state
    uart_state_e tx_state_q, tx_state_d;
    logic [15:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]  tx_idx_q, tx_idx_d;
    logic [7:0]  tx_shift_q, tx_shift_d;
    logic        tx_q, tx_d;
    // RX state
    logic        rx_s1_q, rx_s2_q, rx_prev_q;
    uart_state_e rx_state_q, rx_state_d;
    logic [15:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]  rx_idx_q, rx_idx_d;
    logic [7:0]  rx_shift_q, rx_shift_d;
    logic [7:0]  rx_byte_q, rx_byte_d;
    logic        rx_valid_q, rx_valid_d;
    logic        rx_overrun_q, rx_overrun_d;
    logic        frame_err_q, frame_err_d;

    logic [15:0] div;
    logic [1:0]  reg_sel;
    logic        bus_wr, bus_rd, rx_read, status_clr, rx_done;
    logic        fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [7:0]  fifo_dout;
    logic [31:0] status_w;
    logic        unused_bits;

    assign div        = eff_div(baud_q);
    assign reg_sel    = addr_i[3:2];
    assign bus_wr     = req_i & we_i;
    assign bus_rd     = req_i & ~we_i;
    assign rx_read    = bus_rd && (reg_sel == REG_DATA);
    assign status_clr = bus_wr && (reg_sel == REG_STATUS) && be_i[0] && wdata_i[ST_RX_OVERRUN];
    assign fifo_push  = bus_wr && (reg_sel == REG_DATA) && be_i[0];
    assign status_w   = {27'd0, frame_err_q, rx_overrun_q, rx_valid_q, fifo_full, (tx_state_q != IDLE)};
    assign unused_bits = &{1'b0, addr_i[31:4], addr_i[1:0], wdata_i[31:16], be_i[3:2]};

    assign gnt_o    = req_i;
    assign rvalid_o = rvalid_q;
    assign rdata_o  = rdata_q;
    assign tx_o     = tx_q;
    assign irq_o    = irq_q;

    sync_fifo #(.WIDTH(8), .DEPTH(TX_FIFO_DEPTH)) u_tx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .din   (wdata_i[7:0]),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Bus response, register writes, TX and RX next-state logic
    always_comb begin
        ctrl_d       = ctrl_q;
        baud_d       = baud_q;
        rvalid_d     = req_i;
        rdata_d      = 32'd0;
        irq_d        = rx_valid_q & ctrl_q[CTRL_RX_IRQ_EN];
        tx_state_d   = tx_state_q;
        tx_cnt_d     = tx_cnt_q;
        tx_idx_d     = tx_idx_q;
        tx_shift_d   = tx_shift_q;
        tx_d         = tx_q;
        fifo_pop     = 1'b0;
        rx_state_d   = rx_state_q;
        rx_cnt_d     = rx_cnt_q;
        rx_idx_d     = rx_idx_q;
        rx_shift_d   = rx_shift_q;
        rx_byte_d    = rx_byte_q;
        rx_valid_d   = rx_valid_q;
        rx_overrun_d = rx_overrun_q;
        frame_err_d  = frame_err_q;
        rx_done      = 1'b0;

        if (bus_rd) begin
            case (reg_sel)
                REG_CTRL:   rdata_d = {29'd0, ctrl_q};
                REG_STATUS: rdata_d = status_w;
                REG_BAUD:   rdata_d = {16'd0, baud_q};
                default:    rdata_d = {24'd0, rx_byte_q};
            endcase
        end
        if (bus_wr && reg_sel == REG_CTRL && be_i[0]) ctrl_d = wdata_i[2:0];
        if (bus_wr && reg_sel == REG_BAUD) begin
            if (be_i[0]) baud_d[7:0]  = wdata_i[7:0];
            if (be_i[1]) baud_d[15:8] = wdata_i[15:8];
        end

        // TX: pop on leaving IDLE or on STOP->START for gap-free frames
        case (tx_state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (ctrl_q[CTRL_TX_EN] && !fifo_empty) begin
                    fifo_pop   = 1'b1;
                    tx_shift_d = fifo_dout;
                    tx_cnt_d   = div - 16'd1;
                    tx_d       = 1'b0;
                    tx_state_d = START;
                end
            end
            START, DATA: begin
                if (tx_cnt_q != 16'd0) begin
                    tx_cnt_d = tx_cnt_q - 16'd1;
                end else begin
                    tx_cnt_d = div - 16'd1;
                    if (tx_state_q == DATA && tx_idx_q == 3'd7) begin
                        tx_d       = 1'b1;
                        tx_state_d = STOP;
                    end else begin
                        tx_d       = tx_shift_q[0];
                        tx_shift_d = {1'b0, tx_shift_q[7:1]};
                        tx_idx_d   = (tx_state_q == START) ? 3'd0 : tx_idx_q + 3'd1;
                        tx_state_d = DATA;
                    end
                end
            end
            default: begin
                if (tx_cnt_q != 16'd0) begin
                    tx_cnt_d = tx_cnt_q - 16'd1;
                end else if (ctrl_q[CTRL_TX_EN] && !fifo_empty) begin
                    fifo_pop   = 1'b1;
                    tx_shift_d = fifo_dout;
                    tx_cnt_d   = div - 16'd1;
                    tx_d       = 1'b0;
                    tx_state_d = START;
                end else begin
                    tx_d       = 1'b1;
                    tx_state_d = IDLE;
                end
            end
        endcase

        // RX: flag clears first so a same-cycle event can still set them
        if (status_clr) begin
            rx_overrun_d = 1'b0;
            frame_err_d  = 1'b0;
        end
        if (rx_read) rx_valid_d = 1'b0;

        if (!ctrl_q[CTRL_RX_EN]) begin
            rx_state_d = IDLE;
        end else begin
            case (rx_state_q)
                IDLE: begin
                    if (rx_prev_q && !rx_s2_q) begin
                        rx_cnt_d   = (div >> 1) - 16'd1;
                        rx_state_d = START;
                    end
                end
                START: begin
                    if (rx_cnt_q != 16'd0) begin
                        rx_cnt_d = rx_cnt_q - 16'd1;
                    end else if (rx_s2_q) begin
                        rx_state_d = IDLE;
                    end else begin
                        rx_cnt_d   = div - 16'd1;
                        rx_idx_d   = 3'd0;
                        rx_state_d = DATA;
                    end
                end
                DATA: begin
                    if (rx_cnt_q != 16'd0) begin
                        rx_cnt_d = rx_cnt_q - 16'd1;
                    end else begin
                        rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
                        rx_cnt_d   = div - 16'd1;
                        rx_idx_d   = rx_idx_q + 3'd1;
                        if (rx_idx_q == 3'd7) rx_state_d = STOP;
                    end
                end
                default: begin
                    if (rx_cnt_q != 16'd0) begin
                        rx_cnt_d = rx_cnt_q - 16'd1;
                    end else begin
                        rx_state_d = IDLE;
                        if (!rx_s2_q) frame_err_d = 1'b1;
                        else          rx_done     = 1'b1;
                    end
                end
            endcase
        end

        if (rx_done) begin
            if (rx_valid_q && !rx_read) begin
                rx_overrun_d = 1'b1;
            end else begin
                rx_byte_d  = rx_shift_q;
                rx_valid_d = 1'b1;
            end
        end
    end

    // All state registers; reset drives the TX line idle high at once
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_q       <= 3'd0;
            baud_q       <= DIV_RESET;
            rvalid_q     <= 1'b0;
            rdata_q      <= 32'd0;
            irq_q        <= 1'b0;
            tx_state_q   <= IDLE;
            tx_cnt_q     <= 16'd0;
            tx_idx_q     <= 3'd0;
            tx_shift_q   <= 8'd0;
            tx_q         <= 1'b1;
            rx_s1_q      <= 1'b1;
            rx_s2_q      <= 1'b1;
            rx_prev_q    <= 1'b1;
            rx_state_q   <= IDLE;
            rx_cnt_q     <= 16'd0;
            rx_idx_q     <= 3'd0;
            rx_shift_q   <= 8'd0;
            rx_byte_q    <= 8'd0;
            rx_valid_q   <= 1'b0;
            rx_overrun_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            ctrl_q       <= ctrl_d;
            baud_q       <= baud_d;
            rvalid_q     <= rvalid_d;
            rdata_q      <= rdata_d;
            irq_q        <= irq_d;
            tx_state_q   <= tx_state_d;
            tx_cnt_q     <= tx_cnt_d;
            tx_idx_q     <= tx_idx_d;
            tx_shift_q   <= tx_shift_d;
            tx_q         <= tx_d;
            rx_s1_q      <= rx_i;
            rx_s2_q      <= rx_s1_q;
            rx_prev_q    <= rx_s2_q;
            rx_state_q   <= rx_state_d;
            rx_cnt_q     <= rx_cnt_d;
            rx_idx_q     <= rx_idx_d;
            rx_shift_q   <= rx_shift_d;
            rx_byte_q    <= rx_byte_d;
            rx_valid_q   <= rx_valid_d;
            rx_overrun_q <= rx_overrun_d;
            frame_err_q  <= frame_err_d;
        end
    end

endmodule

// File: tb/tb_obi_uart.sv
// Directed bench for obi_uart: register vector table plus hand-written
// TX waveform, RX frame, error-flag, glitch and reset sequences.
module tb_obi_uart;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_i = 1'b0;
    logic        gnt_o;
    logic        rvalid_o;
    logic [31:0] addr_i = 32'd0;
    logic        we_i = 1'b0;
    logic [3:0]  be_i = 4'd0;
    logic [31:0] wdata_i = 32'd0;
    logic [31:0] rdata_o;
    logic        tx_o;
    logic        rx_i = 1'b1;
    logic        irq_o;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [3:0] A_CTRL = 4'h0, A_STATUS = 4'h4, A_BAUD = 4'h8, A_DATA = 4'hC;

    typedef struct {
        logic        we;
        logic [3:0]  addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[14];

    obi_uart dut (
        .clk      (clk),
        .rst      (rst),
        .req_i    (req_i),
        .gnt_o    (gnt_o),
        .rvalid_o (rvalid_o),
        .addr_i   (addr_i),
        .we_i     (we_i),
        .be_i     (be_i),
        .wdata_i  (wdata_i),
        .rdata_o  (rdata_o),
        .tx_o     (tx_o),
        .rx_i     (rx_i),
        .irq_o    (irq_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One OBI transaction; returns the data seen in the rvalid cycle
    task automatic bus(input logic we, input logic [3:0] addr, input logic [3:0] be,
                       input logic [31:0] wdata, output logic [31:0] rdata);
        @(negedge clk);
        chk("idle_rvalid", {31'd0, rvalid_o}, 32'd0);
        chk("idle_rdata", rdata_o, 32'd0);
        req_i   = 1'b1;
        we_i    = we;
        addr_i  = {28'd0, addr};
        be_i    = be;
        wdata_i = wdata;
        #1;
        chk("gnt", {31'd0, gnt_o}, 32'd1);
        @(negedge clk);
        req_i   = 1'b0;
        we_i    = 1'b0;
        be_i    = 4'd0;
        wdata_i = 32'd0;
        chk("rvalid", {31'd0, rvalid_o}, 32'd1);
        rdata = rdata_o;
        $display("[%0t] %s addr=0x%0h be=0x%0h wdata=0x%0h rdata=0x%0h",
                 $time, we ? "WR" : "RD", addr, be, wdata, rdata);
    endtask

    task automatic wr(input logic [3:0] addr, input logic [3:0] be, input logic [31:0] d);
        logic [31:0] r;
        bus(1'b1, addr, be, d, r);
        chk("wr_rdata", r, 32'd0);
    endtask

    task automatic rd(input string name, input logic [3:0] addr, input logic [31:0] exp);
        logic [31:0] r;
        bus(1'b0, addr, 4'hF, 32'd0, r);
        chk(name, r, exp);
    endtask

    // Check tx_o cycle by cycle over one 8N1 frame
    task automatic tx_frame(input logic [7:0] b, input int div);
        logic [9:0] f;
        f = {1'b1, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            for (int c = 0; c < div; c++) begin
                @(negedge clk);
                chk($sformatf("tx_line byte=0x%0h bit=%0d", b, i), {31'd0, tx_o}, {31'd0, f[i]});
            end
        end
        $display("[%0t] tx frame 0x%0h checked", $time, b);
    endtask

    // Drive one frame onto rx_i with the given stop-bit value
    task automatic rx_send(input logic [7:0] b, input logic stop, input int div);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            for (int c = 0; c < div; c++) begin
                @(negedge clk);
                rx_i = f[i];
            end
        end
        @(negedge clk);
        rx_i = 1'b1;
        $display("[%0t] rx frame 0x%0h stop=%0d sent", $time, b, stop);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r;
        logic [7:0]  q_bytes [5];

        vecs[0]  = '{1'b0, A_BAUD,   4'hF, 32'h0,         32'h0000_01B2};
        vecs[1]  = '{1'b0, A_STATUS, 4'hF, 32'h0,         32'h0};
        vecs[2]  = '{1'b0, A_CTRL,   4'hF, 32'h0,         32'h0};
        vecs[3]  = '{1'b0, A_DATA,   4'hF, 32'h0,         32'h0};
        vecs[4]  = '{1'b1, A_CTRL,   4'hF, 32'hFFFF_FFF6, 32'h0};
        vecs[5]  = '{1'b0, A_CTRL,   4'hF, 32'h0,         32'h6};
        vecs[6]  = '{1'b1, A_CTRL,   4'hE, 32'h0000_0001, 32'h0};
        vecs[7]  = '{1'b0, A_CTRL,   4'hF, 32'h0,         32'h6};
        vecs[8]  = '{1'b1, A_BAUD,   4'h1, 32'h0000_1234, 32'h0};
        vecs[9]  = '{1'b0, A_BAUD,   4'hF, 32'h0,         32'h0000_0134};
        vecs[10] = '{1'b1, A_BAUD,   4'h3, 32'hABCD_0004, 32'h0};
        vecs[11] = '{1'b0, A_BAUD,   4'hF, 32'h0,         32'h4};
        vecs[12] = '{1'b1, A_CTRL,   4'h1, 32'h0,         32'h0};
        vecs[13] = '{1'b0, A_CTRL,   4'hF, 32'h0,         32'h0};

        // Reset
        #2 rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("reset_tx", {31'd0, tx_o}, 32'd1);
        chk("reset_irq", {31'd0, irq_o}, 32'd0);
        chk("reset_rvalid", {31'd0, rvalid_o}, 32'd0);
        chk("reset_rdata", rdata_o, 32'd0);

        // Register vector table
        for (int i = 0; i < 14; i++) begin
            bus(vecs[i].we, vecs[i].addr, vecs[i].be, vecs[i].wdata, r);
            chk($sformatf("reg_vec[%0d]", i), r, vecs[i].exp_rdata);
        end

        // Single TX frame at BAUD=4
        wr(A_CTRL, 4'hF, 32'h1);
        wr(A_DATA, 4'hF, 32'hA5);
        tx_frame(8'hA5, 4);
        rd("tx_done_status", A_STATUS, 32'h0);

        // Queue 5 bytes with TX disabled: 4 held, 5th dropped
        wr(A_CTRL, 4'hF, 32'h0);
        q_bytes[0] = 8'h11; q_bytes[1] = 8'h22; q_bytes[2] = 8'h33;
        q_bytes[3] = 8'h44; q_bytes[4] = 8'h55;
        for (int i = 0; i < 5; i++) wr(A_DATA, 4'h1, {24'd0, q_bytes[i]});
        rd("fifo_full_status", A_STATUS, 32'h2);
        wr(A_CTRL, 4'hF, 32'h1);
        for (int i = 0; i < 4; i++) tx_frame(q_bytes[i], 4);
        rd("b2b_done_status", A_STATUS, 32'h0);

        // RX of 0x3C at BAUD=8 with interrupt enabled
        wr(A_BAUD, 4'h3, 32'h8);
        wr(A_CTRL, 4'hF, 32'h7);
        rx_send(8'h3C, 1'b1, 8);
        repeat (3) @(negedge clk);
        chk("rx_irq_set", {31'd0, irq_o}, 32'd1);
        rd("rx_status", A_STATUS, 32'h4);
        rd("rx_data", A_DATA, 32'h3C);
        chk("irq_lag", {31'd0, irq_o}, 32'd1);
        @(negedge clk);
        chk("irq_clear", {31'd0, irq_o}, 32'd0);
        rd("rx_status_clr", A_STATUS, 32'h0);

        // Overrun: second frame arrives before the first is read
        rx_send(8'h5A, 1'b1, 8);
        repeat (2) @(negedge clk);
        rx_send(8'hC3, 1'b1, 8);
        repeat (3) @(negedge clk);
        rd("overrun_status", A_STATUS, 32'hC);
        rd("overrun_data", A_DATA, 32'h5A);
        rd("overrun_after_read", A_STATUS, 32'h8);

        // Framing error, then clear both sticky flags
        rx_send(8'h77, 1'b0, 8);
        repeat (3) @(negedge clk);
        rd("frame_err_status", A_STATUS, 32'h18);
        wr(A_STATUS, 4'h1, 32'h8);
        rd("flags_cleared", A_STATUS, 32'h0);

        // Two-cycle glitch is rejected as a false start
        @(negedge clk); rx_i = 1'b0;
        @(negedge clk);
        @(negedge clk); rx_i = 1'b1;
        repeat (20) @(negedge clk);
        chk("glitch_irq", {31'd0, irq_o}, 32'd0);
        rd("glitch_status", A_STATUS, 32'h0);

        // Reset in the middle of a frame
        wr(A_BAUD, 4'h3, 32'h4);
        wr(A_CTRL, 4'hF, 32'h1);
        wr(A_DATA, 4'h1, 32'h00);
        wr(A_DATA, 4'h1, 32'h00);
        repeat (4) @(negedge clk);
        chk("mid_frame_tx_low", {31'd0, tx_o}, 32'd0);
        rst = 1'b1;
        #1;
        chk("reset_tx_immediate", {31'd0, tx_o}, 32'd1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        rd("post_reset_status", A_STATUS, 32'h0);
        rd("post_reset_baud", A_BAUD, 32'h1B2);
        rd("post_reset_ctrl", A_CTRL, 32'h0);
        repeat (5) @(negedge clk);
        chk("post_reset_tx_idle", {31'd0, tx_o}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
